// File: rtl/max7219_stream_tx.sv
// Serialises MAX7219 init and display-refresh traffic for a DISP_ROWS x DISP_COLUMNS daisy chain.
// Runs the init sequence once, then refreshes row-slots 0..7 from a per-frame snapshot.
module max7219_stream_tx #(
    parameter int unsigned DISP_ROWS    = 1,
    parameter int unsigned DISP_COLUMNS = 1,
    parameter int unsigned CLK_DIV      = 4,
    parameter logic [3:0]  INTENSITY    = 4'h8
) (
    input  logic                                            i_Clk,
    input  logic                                            i_Rst,
    input  logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] i_MAX7219_DataStream,
    output logic                                            o_MAX7219_DIN,
    output logic                                            o_MAX7219_CLK,
    output logic                                            o_MAX7219_CS,
    output logic                                            o_FrameDone,
    output logic                                            o_InitDone
);

    localparam int unsigned N  = DISP_ROWS * DISP_COLUMNS;
    localparam int unsigned SW = 16 * N;
    localparam int unsigned BW = $clog2(SW);
    localparam int unsigned CW = $clog2(2 * CLK_DIV);

    localparam logic [CW-1:0] DivLast   = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HighStart = CW'(CLK_DIV);
    localparam logic [BW-1:0] BitLast   = BW'(SW - 1);

    typedef enum logic [2:0] {
        StInitLoad,
        StSnapshot,
        StShift,
        StLatch,
        StNext
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [2:0]      slot_q, slot_d;
    logic [2:0]      init_idx_q, init_idx_d;
    logic            framing_q, framing_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            din_q, din_d;
    logic            frame_done_q, frame_done_d;
    logic            init_done_q, init_done_d;
    logic [SW-1:0]   load_vec;
    logic [15:0]     init_word;

    logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] snap_q;

    // Word set for the transaction about to start; device N-1 lands in the top bits so it
    // leaves the shifter first.
    always_comb begin
        case (init_idx_q)
            3'd0:    init_word = 16'h0C01;
            3'd1:    init_word = 16'h0B07;
            3'd2:    init_word = 16'h0900;
            3'd3:    init_word = {12'h0A0, INTENSITY};
            3'd4:    init_word = 16'h0F00;
            default: init_word = 16'h0C01;
        endcase
        load_vec = '0;
        for (int unsigned r = 0; r < DISP_ROWS; r++) begin
            for (int unsigned c = 0; c < DISP_COLUMNS; c++) begin
                if (state_q == StInitLoad) begin
                    load_vec[16*(r*DISP_COLUMNS+c) +: 16] = init_word;
                end else if (state_q == StSnapshot) begin
                    load_vec[16*(r*DISP_COLUMNS+c) +: 16] = i_MAX7219_DataStream[0][r][c];
                end else begin
                    load_vec[16*(r*DISP_COLUMNS+c) +: 16] = snap_q[slot_q][r][c];
                end
            end
        end
    end

    // Outputs are registered, so each state computes what the pins show on the next cycle.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        slot_d       = slot_q;
        init_idx_d   = init_idx_q;
        framing_d    = framing_q;
        shreg_d      = shreg_q;
        cs_d         = 1'b1;
        sclk_d       = 1'b0;
        din_d        = 1'b0;
        frame_done_d = 1'b0;
        init_done_d  = init_done_q;

        unique case (state_q)
            StInitLoad, StSnapshot, StNext: begin
                shreg_d = load_vec;
                cs_d    = 1'b0;
                din_d   = load_vec[SW-1];
                div_d   = '0;
                bit_d   = '0;
                state_d = StShift;
            end
            StShift: begin
                cs_d   = 1'b0;
                sclk_d = (div_q >= HighStart);
                din_d  = shreg_q[SW-1];
                if (div_q == DivLast) begin
                    div_d   = '0;
                    shreg_d = shreg_q << 1;
                    if (bit_q == BitLast) begin
                        state_d = StLatch;
                        if (!framing_q && init_idx_q == 3'd4) begin
                            init_done_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StLatch: begin
                if (div_q == DivLast) begin
                    div_d = '0;
                    if (!framing_q) begin
                        if (init_idx_q == 3'd4) begin
                            framing_d = 1'b1;
                            slot_d    = 3'd0;
                            state_d   = StSnapshot;
                        end else begin
                            init_idx_d = init_idx_q + 3'd1;
                            state_d    = StInitLoad;
                        end
                    end else if (slot_q == 3'd7) begin
                        // Explicit terminal slot; the 3-bit wrap is not relied on.
                        frame_done_d = 1'b1;
                        slot_d       = 3'd0;
                        state_d      = StSnapshot;
                    end else begin
                        slot_d  = slot_q + 3'd1;
                        state_d = StNext;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StInitLoad;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= StInitLoad;
            div_q        <= '0;
            bit_q        <= '0;
            slot_q       <= 3'd0;
            init_idx_q   <= 3'd0;
            framing_q    <= 1'b0;
            shreg_q      <= '0;
            cs_q         <= 1'b1;
            sclk_q       <= 1'b0;
            din_q        <= 1'b0;
            frame_done_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            slot_q       <= slot_d;
            init_idx_q   <= init_idx_d;
            framing_q    <= framing_d;
            shreg_q      <= shreg_d;
            cs_q         <= cs_d;
            sclk_q       <= sclk_d;
            din_q        <= din_d;
            frame_done_q <= frame_done_d;
            init_done_q  <= init_done_d;
        end
    end

    // The whole frame is sent from this copy so upstream edits take effect only at frame start.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            snap_q <= '0;
        end else if (state_q == StSnapshot) begin
            snap_q <= i_MAX7219_DataStream;
        end
    end

    assign o_MAX7219_DIN = din_q;
    assign o_MAX7219_CLK = sclk_q;
    assign o_MAX7219_CS  = cs_q;
    assign o_FrameDone   = frame_done_q;
    assign o_InitDone    = init_done_q;

endmodule

// File: doc/max7219_stream_tx.md
MAX7219_STREAM_TX -- requirements
Module: max7219_stream_tx

Interface
REQ-001 SHALL have parameter DISP_ROWS, default 1, number of display rows in the MAX7219 chain.
REQ-002 SHALL have parameter DISP_COLUMNS, default 1, number of display columns in the MAX7219 chain.
REQ-003 SHALL have parameter CLK_DIV, default 4 (legal ≥1), number of i_Clk cycles per SCLK half-period.
REQ-004 SHALL have parameter INTENSITY, default 4'h8, intensity code sent during init.
REQ-005 SHALL have port i_Clk, input, 1 bit: the single clock.
REQ-006 SHALL have port i_Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port i_MAX7219_DataStream, input, [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0]: per row-slot, per device, complete {addr,data} word, consumed from the upstream pattern generator.
REQ-008 SHALL have port o_MAX7219_DIN, output, 1 bit: serial data, MSB first.
REQ-009 SHALL have port o_MAX7219_CLK, output, 1 bit: serial clock.
REQ-010 SHALL have port o_MAX7219_CS, output, 1 bit: LOAD/CS, active-low.
REQ-011 SHALL have port o_FrameDone, output, 1 bit: one-cycle pulse after row-slot 7 of a frame is latched.
REQ-012 SHALL have port o_InitDone, output, 1 bit: level, high once the init sequence completes.

Function
REQ-013 SHALL define N = DISP_ROWS*DISP_COLUMNS and device index k = r*DISP_COLUMNS + c, where device 0 is nearest the FPGA.
REQ-014 SHALL shift each transaction as N consecutive 16-bit words, in order k = N-1 down to 0, MSB first, with no gaps between words.
REQ-015 SHALL keep SCLK idle low; per bit: DIN valid at SCLK low start, SCLK low CLK_DIV cycles then high CLK_DIV cycles, so 1 bit = 2*CLK_DIV i_Clk cycles.
REQ-016 SHALL drive CS low from the first i_Clk cycle of the transaction until the last SCLK high phase ends, then drive CS high for 2*CLK_DIV cycles (the latch/gap) before the next transaction.
REQ-017 SHALL implement FSM states INIT_LOAD, SNAPSHOT, SHIFT, LATCH, NEXT.
REQ-018 SHALL, in INIT_LOAD, send 5 transactions in the order 16'h0C01, 16'h0B07, 16'h0900, 16'h0A0{INTENSITY}, 16'h0F00, each transaction sending the same word to all N devices.
REQ-019 SHALL set o_InitDone on the gap cycle after the 5th init transaction and hold it until reset.
REQ-020 SHALL, in SNAPSHOT, register the entire i_MAX7219_DataStream in one cycle; the whole frame transmits from this copy, so input changes mid-frame have no effect until the next SNAPSHOT.
REQ-021 SHALL transmit row-slots 0..7 in order, one transaction each, with words taken from snapshot[slot][r][c].
REQ-022 SHALL, after the slot-7 gap, pulse o_FrameDone high for exactly one cycle and enter SNAPSHOT on the next cycle (continuous refresh, no idle).
REQ-023 SHALL have frame length 8*(32*N*CLK_DIV + 2*CLK_DIV + 1) cycles (+1 is SNAPSHOT/NEXT overhead as implemented; the bench measures the constant and it SHALL be fixed).
REQ-024 SHALL size the bit counter for 16*N and the slot counter as 3 bits, and SHALL terminate on slot==7 rather than relying on wrap.
REQ-025 SHALL hold DIN at 0 whenever CS is high.

Reset
REQ-026 SHALL, on i_Rst high (asynchronous), immediately drive o_MAX7219_CLK=0, o_MAX7219_DIN=0, o_MAX7219_CS=1, o_FrameDone=0, o_InitDone=0, clear all counters and the snapshot, and set the state to INIT_LOAD.
REQ-027 SHALL, on reset asserted mid-transaction, force CS high within the same cycle, discard the partial word, and restart from the full init sequence after release.
REQ-028 SHALL begin the first init transaction (CS low) on the first i_Clk rising edge after i_Rst deasserts.

Verification
REQ-029 SHALL be verified with N=1, CLK_DIV=1, reset release: first 16 SCLK rises sample 0x0C01, then CS rises; the 5 init words match in order and o_InitDone rises after the 5th.
REQ-030 SHALL be verified with N=1, all slot words = 16'h0100+slot: after init, 8 transactions decode as 0x0100..0x0107, followed by exactly one o_FrameDone pulse.
REQ-031 SHALL be verified with DISP_ROWS=1, DISP_COLUMNS=2, slot0 = {c0:0x01AA, c1:0x0155}: 32 bits under one CS low decode as 0x0155 then 0x01AA.
REQ-032 SHALL be verified by changing the input stream during slot 3: the current frame shows only old values and the next frame shows new values.
REQ-033 SHALL be verified by asserting i_Rst mid-word: CS=1, CLK=0 and DIN=0 follow asynchronously, and after release the sequence restarts with 0x0C01.
REQ-034 SHALL be verified with CLK_DIV=4: the SCLK high/low phases measure exactly 4 cycles each and the CS-high gap measures 8 cycles.
